// File: rtl/dm_responder.sv
// dm_responder: word-addressed data memory for a CPU M stage, with a
// first-word-fall-through queue that traces every accepted in-range store.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   m_data_addr    byte address (bits [1:0] ignored for the word index)
//   m_data_wdata   lane-aligned store data
//   m_data_byteen  byte write enables, nonzero = store
//   m_inst_addr    PC of the M-stage instruction
//   m_data_rdata   combinational read data (0 when out of range)
//   trace_valid    queue head record valid
//   trace_ready    consumer accepts head record
//   trace_pc       head record PC
//   trace_addr     head record word-aligned address
//   trace_data     head record merged word
//   trace_byteen   head record byte enables
//   addr_err       sticky out-of-range store flag
//   ovf            sticky trace queue overflow flag
//   err_clr        synchronous clear of addr_err / ovf (set wins)
module dm_responder #(
  parameter int DM_WORDS = 3072,
  parameter int TQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_byteen,
  output logic        addr_err,
  output logic        ovf,
  input  logic        err_clr
);

  localparam int IDX_W = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  localparam int PTR_W = $clog2(TQ_DEPTH);
  // 33 bits so 4*DM_WORDS can never wrap in the range compare.
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(TQ_DEPTH);

  logic [31:0] r_mem [DM_WORDS];

  logic [31:0] r_tq_pc   [TQ_DEPTH];
  logic [31:0] r_tq_addr [TQ_DEPTH];
  logic [31:0] r_tq_data [TQ_DEPTH];
  logic [3:0]  r_tq_be   [TQ_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_addr_err;
  logic             r_ovf;
  logic             r_run;

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_old_word;
  logic [31:0]      w_merged;
  logic             w_store;
  logic             w_wr;
  logic             w_oor;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_in_range = ({1'b0, m_data_addr} < DM_BYTES);
  assign w_idx      = m_data_addr[IDX_W+1:2];
  assign w_old_word = r_mem[w_idx];

  assign m_data_rdata = w_in_range ? w_old_word : 32'h0;

  // r_run stays low for the first edge after reset release, so a store that
  // lands on the release edge is neither written nor traced nor flagged.
  assign w_store = (m_data_byteen != 4'b0000) && r_run;
  assign w_wr    = w_store && w_in_range;
  assign w_oor   = w_store && !w_in_range;

  always_comb begin
    w_merged = w_old_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) begin
        w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
      end
    end
  end

  assign trace_valid = (r_count != '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = trace_valid && trace_ready;
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign w_push      = w_wr && (!w_full || w_pop);
  assign w_drop      = w_wr && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tq_pc[r_wr_ptr]   <= m_inst_addr;
      r_tq_addr[r_wr_ptr] <= {m_data_addr[31:2], 2'b00};
      r_tq_data[r_wr_ptr] <= w_merged;
      r_tq_be[r_wr_ptr]   <= m_data_byteen;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_oor) begin
        r_addr_err <= 1'b1;
      end else if (err_clr) begin
        r_addr_err <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign addr_err = r_addr_err;
  assign ovf      = r_ovf;

  assign trace_pc     = trace_valid ? r_tq_pc[r_rd_ptr]   : 32'h0;
  assign trace_addr   = trace_valid ? r_tq_addr[r_rd_ptr] : 32'h0;
  assign trace_data   = trace_valid ? r_tq_data[r_rd_ptr] : 32'h0;
  assign trace_byteen = trace_valid ? r_tq_be[r_rd_ptr]   : 4'h0;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  localparam int DM_WORDS = 3072;
  localparam int TQ_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] pc;
  logic        ready;
  logic        clr;
  logic [31:0] rdata;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_byteen;
  logic        addr_err;
  logic        ovf;

  dm_responder #(.DM_WORDS(DM_WORDS), .TQ_DEPTH(TQ_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .m_data_addr(addr),
    .m_data_wdata(wdata),
    .m_data_byteen(be),
    .m_inst_addr(pc),
    .m_data_rdata(rdata),
    .trace_valid(trace_valid),
    .trace_ready(ready),
    .trace_pc(trace_pc),
    .trace_addr(trace_addr),
    .trace_data(trace_data),
    .trace_byteen(trace_byteen),
    .addr_err(addr_err),
    .ovf(ovf),
    .err_clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } rec_t;

  // Reference model: word memory, record queue, sticky flags.
  logic [31:0] m_mem [int];
  rec_t        m_q [$];
  logic        m_aerr;
  logic        m_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return longint'(a) < longint'(4 * DM_WORDS);
  endfunction

  task automatic check_outputs();
    rec_t h;
    if (!in_range(addr)) chk("rdata_oor", rdata, 32'h0);
    else if (m_mem.exists(int'(addr >> 2))) chk("rdata", rdata, m_mem[int'(addr >> 2)]);
    chk("trace_valid", {31'b0, trace_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) h = m_q[0];
    else h = '{pc: 32'h0, addr: 32'h0, data: 32'h0, be: 4'h0};
    chk("trace_pc", trace_pc, h.pc);
    chk("trace_addr", trace_addr, h.addr);
    chk("trace_data", trace_data, h.data);
    chk("trace_byteen", {28'b0, trace_byteen}, {28'b0, h.be});
    chk("addr_err", {31'b0, addr_err}, {31'b0, m_aerr});
    chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
  endtask

  task automatic model_edge();
    bit   pop;
    bit   set_a;
    bit   set_o;
    logic [31:0] old;
    logic [31:0] merged;
    rec_t r;
    if (!reset) begin
      m_q.delete();
      m_aerr = 1'b0;
      m_ovf  = 1'b0;
      return;
    end
    pop   = (m_q.size() != 0) && ready;
    set_a = 1'b0;
    set_o = 1'b0;
    if (be != 4'b0) begin
      if (in_range(addr)) begin
        old = m_mem.exists(int'(addr >> 2)) ? m_mem[int'(addr >> 2)] : 32'h0;
        merged = old;
        for (int i = 0; i < 4; i++)
          if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        m_mem[int'(addr >> 2)] = merged;
        if (m_q.size() < TQ_DEPTH || pop) begin
          r.pc = pc; r.addr = addr & 32'hFFFF_FFFC; r.data = merged; r.be = be;
          m_q.push_back(r);
        end else begin
          set_o = 1'b1;
        end
      end else begin
        set_a = 1'b1;
      end
    end
    if (pop) void'(m_q.pop_front());
    m_aerr = set_a | (m_aerr & ~clr);
    m_ovf  = set_o | (m_ovf & ~clr);
  endtask

  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [31:0] a, input logic rdy);
    addr = a; wdata = 32'h0; be = 4'b0; pc = 32'h0; ready = rdy; clr = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic [31:0] p);
    addr = a; wdata = d; be = b; pc = p; clr = 1'b0;
    cyc();
  endtask

  task automatic drain(output int n, output logic [31:0] last_pc);
    n = 0;
    last_pc = 32'h0;
    idle(32'h0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!trace_valid) break;
      last_pc = trace_pc;
      n++;
      cyc();
    end
  endtask

  initial begin
    int          n;
    logic [31:0] lp;
    logic [31:0] saved;
    logic [31:0] first_pc;
    logic [31:0] a;

    m_aerr = 1'b0;
    m_ovf  = 1'b0;
    reset  = 1'b0;
    idle(32'h0, 1'b0);
    #1;
    chk("reset_valid", {31'b0, trace_valid}, 32'h0);
    chk("reset_pc", trace_pc, 32'h0);
    chk("reset_flags", {30'b0, addr_err, ovf}, 32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    // Give every word the bench will touch a known value.
    ready = 1'b1;
    for (int w = 0; w < 16; w++) st(32'(w * 4), $urandom, 4'hF, 32'h1000 + 32'(w * 4));
    st(32'h100, $urandom, 4'hF, 32'h1100);
    st(32'h2FFC, 32'hCAFE_F00D, 4'hF, 32'h1104);
    drain(n, lp);

    // Byte merge.
    ready = 1'b0;
    st(32'h100, 32'h1122_3344, 4'b1111, 32'h2000);
    st(32'h100, 32'hAAAA_AAAA, 4'b0010, 32'h2004);
    idle(32'h100, 1'b1);
    #1;
    chk("merge_rdata", rdata, 32'h1122_AA44);
    cyc();
    chk("merge_rec_data", trace_data, 32'h1122_AA44);
    chk("merge_rec_be", {28'b0, trace_byteen}, 32'h2);
    drain(n, lp);

    // Read during write.
    saved = m_mem[2];
    addr = 32'h8; wdata = 32'h5; be = 4'hF; pc = 32'h3000;
    #1;
    chk("rdw_old", rdata, saved);
    cyc();
    idle(32'h8, 1'b1);
    #1;
    chk("rdw_new", rdata, 32'h5);
    cyc();
    drain(n, lp);

    // Out of range store, boundary word just below stays intact.
    st(32'h3000, 32'hDEAD_BEEF, 4'hF, 32'h3100);
    idle(32'h2FFC, 1'b1);
    #1;
    chk("oor_flag", {31'b0, addr_err}, 32'h1);
    chk("oor_no_rec", {31'b0, trace_valid}, 32'h0);
    chk("oor_boundary", rdata, 32'hCAFE_F00D);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    chk("oor_clr", {31'b0, addr_err}, 32'h0);

    // Overflow: five stores into a four-deep queue.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) st(32'(i * 4), 32'h100 + 32'(i), 4'hF, 32'h4000 + 32'(i * 4));
    idle(32'h0, 1'b0);
    #1;
    chk("ovf_set", {31'b0, ovf}, 32'h1);
    chk("ovf_head", trace_pc, 32'h4000);
    drain(n, lp);
    chk("ovf_drain_n", 32'(n), 32'd4);
    chk("ovf_drain_last", lp, 32'h400C);
    clr = 1'b1;
    cyc();

    // Full queue with simultaneous push and pop.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) st(32'(i * 4), 32'h200 + 32'(i), 4'hF, 32'h5000 + 32'(i * 4));
    ready = 1'b1;
    st(32'h10, 32'h299, 4'hF, 32'h5100);
    idle(32'h0, 1'b0);
    #1;
    chk("full_pp_ovf", {31'b0, ovf}, 32'h0);
    drain(n, lp);
    chk("full_pp_n", 32'(n), 32'd4);
    chk("full_pp_last", lp, 32'h5100);

    // Reset mid-stream.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) st(32'h14, 32'h600 + 32'(i), 4'hF, 32'h6000 + 32'(i * 4));
    saved = m_mem[5];
    idle(32'h14, 1'b0);
    reset = 1'b0;
    m_q.delete();
    m_aerr = 1'b0;
    m_ovf  = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, trace_valid}, 32'h0);
    chk("rst_async_pc", trace_pc, 32'h0);
    st(32'h14, 32'hFFFF_FFFF, 4'hF, 32'h6100);
    reset = 1'b1;
    idle(32'h14, 1'b1);
    #1;
    chk("rst_mem_kept", rdata, saved);
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h3000 + $urandom_range(0, 255);
        1:       a = $urandom | 32'h8000_0000;
        default: a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      endcase
      addr  = a;
      wdata = $urandom;
      be    = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      pc    = $urandom & 32'hFFFF_FFFC;
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      cyc();
    end
    drain(n, lp);
    chk("final_empty", {31'b0, trace_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
